// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction-fetch requester: FSM encoding, default widths,
// and the small helper that says which states honour a redirect.
package inst_fetch_pkg;

  localparam int IF_AW = 5;
  localparam int IF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // IDLE has nothing to discard and HALT is only left through reset.
  function automatic logic redirect_ok(input fetch_state_e s);
    return (s == ST_RUN) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch bus bundle: instruction-memory read port, execute redirect, and decode handshake.
// The master modport is the fetch unit; the slave modport is its surroundings.
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int AW = IF_AW,
  parameter int DW = IF_DW
);

  logic [AW-1:0] imem_addr;
  logic          imem_rd_en;
  logic [DW-1:0] imem_data;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          halt;

  modport master (
    output imem_addr, imem_rd_en, inst, inst_pc, inst_valid, halt,
    input  imem_data, redirect, redirect_addr, inst_ready
  );

  modport slave (
    input  imem_addr, imem_rd_en, inst, inst_pc, inst_valid, halt,
    output imem_data, redirect, redirect_addr, inst_ready
  );

endinterface

// File: rtl/inst_fetch_skid.sv
// One-entry holding register for a returned {instruction, pc} pair that arrived
// while the decode output was stalled.
module inst_fetch_skid #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [DW+AW-1:0] push_data,
  output logic [DW+AW-1:0] pop_data,
  output logic             full
);

  logic [DW+AW-1:0] data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  assign pop_data = data;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch requester: owns the PC, issues one word read per cycle, and
// hands {instruction, pc} to decode. Build option: IFETCH_HALT_ON_ZERO_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int            AW       = IF_AW,
  parameter int            DW       = IF_DW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  inst_fetch_if.master bus
);

  fetch_state_e  state, state_nxt;
  logic [AW-1:0] pc;
  logic [AW-1:0] req_pc;
  logic          inflight;

  logic          out_valid;
  logic [DW-1:0] out_inst;
  logic [AW-1:0] out_pc;

  logic          take, rsp, zero_hit, rsp_keep, out_free;
  logic          skid_full, skid_push, skid_pop;
  logic [DW+AW-1:0] skid_data;
  logic          issue_ok, issue;

  // The memory answers combinationally to the registered request, so the word on
  // imem_data belongs to req_pc whenever inflight is set.
  always_comb begin
    take      = bus.redirect && redirect_ok(state);
    rsp       = inflight && !take;
`ifdef IFETCH_HALT_ON_ZERO_EN
    zero_hit  = rsp && (bus.imem_data == '0);
`else
    zero_hit  = 1'b0;
`endif
    rsp_keep  = rsp && !zero_hit;
    out_free  = !out_valid || bus.inst_ready;
    skid_pop  = skid_full && out_free && !take;
    skid_push = rsp_keep && !out_free;
    // A draining skid counts as empty so a stall releases without a bubble.
    issue_ok  = (!skid_full || skid_pop) &&
                !(out_valid && !bus.inst_ready && inflight);

    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_RUN;
      ST_RUN: begin
        if (take)          state_nxt = ST_FLUSH;
        else if (zero_hit) state_nxt = ST_HALT;
      end
      ST_FLUSH: state_nxt = take ? ST_FLUSH : ST_RUN;
      default:  state_nxt = ST_HALT;
    endcase

    issue = (state_nxt == ST_RUN) && issue_ok;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) req_pc <= pc;
      if (take)       pc <= bus.redirect_addr;
      else if (issue) pc <= pc + 1'b1;
    end
  end

  // Skid content always predates any new response, so it drains first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (take) begin
      out_valid <= 1'b0;
    end else if (skid_pop) begin
      out_valid           <= 1'b1;
      {out_inst, out_pc}  <= skid_data;
    end else if (rsp_keep && out_free) begin
      out_valid <= 1'b1;
      out_inst  <= bus.imem_data;
      out_pc    <= req_pc;
    end else if (bus.inst_ready) begin
      out_valid <= 1'b0;
    end
  end

  inst_fetch_skid #(.DW(DW), .AW(AW)) u_skid (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .flush     (take),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_data ({bus.imem_data, req_pc}),
    .pop_data  (skid_data),
    .full      (skid_full)
  );

`ifdef IFETCH_HALT_ON_ZERO_EN
  logic halt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        halt_q <= 1'b0;
    else if (zero_hit) halt_q <= 1'b1;
  end

  assign bus.halt = halt_q;
`else
  assign bus.halt = 1'b0;
`endif

  assign bus.imem_addr  = req_pc;
  assign bus.imem_rd_en = inflight;
  assign bus.inst       = out_inst;
  assign bus.inst_pc    = out_pc;
  assign bus.inst_valid = out_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming, stall/skid, redirect, pc wrap,
// zero-word end-of-program, and asynchronous mid-stream reset.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inst_fetch_if #(.AW(5), .DW(32)) bus0 ();
  inst_fetch_if #(.AW(5), .DW(32)) bus1 ();

  inst_fetch #(.AW(5), .DW(32), .RESET_PC(5'd0)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus0)
  );

  inst_fetch #(.AW(5), .DW(32), .RESET_PC(5'd30)) dut30 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  assign bus0.imem_data = bus0.imem_rd_en ? mem0[bus0.imem_addr] : 32'h0;
  assign bus1.imem_data = bus1.imem_rd_en ? mem1[bus1.imem_addr] : 32'h0;

  function automatic logic [31:0] w0f(input int k);
    return 32'hA500_0000 + 32'(k);
  endfunction

  function automatic logic [31:0] w1f(input int k);
    return 32'hB000_0000 + 32'(k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (DUT in IDLE) right after release.
  task automatic reset_dut();
    rst_n              = 1'b0;
    bus0.redirect      = 1'b0;
    bus0.redirect_addr = '0;
    bus0.inst_ready    = 1'b1;
    bus1.redirect      = 1'b0;
    bus1.redirect_addr = '0;
    bus1.inst_ready    = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus0.imem_addr, bus0.imem_rd_en, bus0.inst, bus0.inst_pc, bus0.inst_valid, bus0.halt} !== 45'd0) begin
      n_err++;
      $display("FAIL reset_outputs got addr=%0d rd=%0b inst=%h pc=%0d v=%0b halt=%0b want all 0",
               bus0.imem_addr, bus0.imem_rd_en, bus0.inst, bus0.inst_pc, bus0.inst_valid, bus0.halt);
    end
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (bus0.imem_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_issue got rd=%0b want 0", bus0.imem_rd_en);
    end
  endtask

  task automatic test_stream();
    reset_dut();
    tick();
    n_cmp++;
    if ({bus0.imem_rd_en, bus0.imem_addr, bus0.inst_valid} !== {1'b1, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL stream_first_req got rd=%0b addr=%0d v=%0b want rd=1 addr=0 v=0",
               bus0.imem_rd_en, bus0.imem_addr, bus0.inst_valid);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if ({bus0.inst_valid, bus0.inst_pc, bus0.inst} !== {1'b1, 5'(k), w0f(k)}) begin
        n_err++;
        $display("FAIL stream_w%0d got v=%0b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                 k, bus0.inst_valid, bus0.inst_pc, bus0.inst, k, w0f(k));
      end
    end
  endtask

  task automatic test_stall();
    reset_dut();
    tick();
    tick();
    tick();
    bus0.inst_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      n_cmp++;
      if ({bus0.inst_valid, bus0.inst_pc, bus0.inst} !== {1'b1, 5'd1, w0f(1)}) begin
        n_err++;
        $display("FAIL stall_hold%0d got v=%0b pc=%0d inst=%h want v=1 pc=1 inst=%h",
                 c, bus0.inst_valid, bus0.inst_pc, bus0.inst, w0f(1));
      end
    end
    tick();
    n_cmp++;
    if ({bus0.inst_valid, bus0.inst_pc, bus0.imem_rd_en} !== {1'b1, 5'd1, 1'b0}) begin
      n_err++;
      $display("FAIL stall_no_issue got v=%0b pc=%0d rd=%0b want v=1 pc=1 rd=0",
               bus0.inst_valid, bus0.inst_pc, bus0.imem_rd_en);
    end
    bus0.inst_ready = 1'b1;
    for (int k = 2; k < 5; k++) begin
      tick();
      n_cmp++;
      if ({bus0.inst_valid, bus0.inst_pc, bus0.inst} !== {1'b1, 5'(k), w0f(k)}) begin
        n_err++;
        $display("FAIL stall_drain_w%0d got v=%0b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                 k, bus0.inst_valid, bus0.inst_pc, bus0.inst, k, w0f(k));
      end
    end
  endtask

  task automatic test_redirect();
    reset_dut();
    tick();
    tick();
    tick();
    n_cmp++;
    if ({bus0.imem_rd_en, bus0.imem_addr} !== {1'b1, 5'd2}) begin
      n_err++;
      $display("FAIL redir_inflight got rd=%0b addr=%0d want rd=1 addr=2", bus0.imem_rd_en, bus0.imem_addr);
    end
    bus0.redirect      = 1'b1;
    bus0.redirect_addr = 5'd4;
    tick();
    bus0.redirect = 1'b0;
    n_cmp++;
    if ({bus0.inst_valid, bus0.imem_rd_en} !== 2'b00) begin
      n_err++;
      $display("FAIL redir_flush got v=%0b rd=%0b want v=0 rd=0", bus0.inst_valid, bus0.imem_rd_en);
    end
    tick();
    n_cmp++;
    if ({bus0.inst_valid, bus0.imem_rd_en, bus0.imem_addr} !== {1'b0, 1'b1, 5'd4}) begin
      n_err++;
      $display("FAIL redir_resume got v=%0b rd=%0b addr=%0d want v=0 rd=1 addr=4",
               bus0.inst_valid, bus0.imem_rd_en, bus0.imem_addr);
    end
    for (int k = 4; k < 6; k++) begin
      tick();
      n_cmp++;
      if ({bus0.inst_valid, bus0.inst_pc, bus0.inst} !== {1'b1, 5'(k), w0f(k)}) begin
        n_err++;
        $display("FAIL redir_w%0d got v=%0b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                 k, bus0.inst_valid, bus0.inst_pc, bus0.inst, k, w0f(k));
      end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_pc [4];
    exp_pc[0] = 5'd30; exp_pc[1] = 5'd31; exp_pc[2] = 5'd0; exp_pc[3] = 5'd1;
    reset_dut();
    tick();
    n_cmp++;
    if ({bus1.imem_rd_en, bus1.imem_addr} !== {1'b1, 5'd30}) begin
      n_err++;
      $display("FAIL wrap_first_req got rd=%0b addr=%0d want rd=1 addr=30", bus1.imem_rd_en, bus1.imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({bus1.inst_valid, bus1.inst_pc, bus1.inst} !== {1'b1, exp_pc[i], w1f(int'(exp_pc[i]))}) begin
        n_err++;
        $display("FAIL wrap_%0d got v=%0b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                 i, bus1.inst_valid, bus1.inst_pc, bus1.inst, exp_pc[i], w1f(int'(exp_pc[i])));
      end
    end
  endtask

  task automatic test_zero_word();
    mem0[6] = 32'h0;
    reset_dut();
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if ({bus0.inst_valid, bus0.inst_pc, bus0.inst, bus0.halt} !== {1'b1, 5'(k), w0f(k), 1'b0}) begin
        n_err++;
        $display("FAIL zero_w%0d got v=%0b pc=%0d inst=%h halt=%0b want v=1 pc=%0d inst=%h halt=0",
                 k, bus0.inst_valid, bus0.inst_pc, bus0.inst, bus0.halt, k, w0f(k));
      end
    end
    tick();
`ifdef IFETCH_HALT_ON_ZERO_EN
    n_cmp++;
    if ({bus0.halt, bus0.inst_valid, bus0.imem_rd_en} !== 3'b100) begin
      n_err++;
      $display("FAIL zero_halt got halt=%0b v=%0b rd=%0b want halt=1 v=0 rd=0",
               bus0.halt, bus0.inst_valid, bus0.imem_rd_en);
    end
    bus0.redirect      = 1'b1;
    bus0.redirect_addr = 5'd2;
    tick();
    bus0.redirect = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus0.halt, bus0.inst_valid, bus0.imem_rd_en} !== 3'b100) begin
      n_err++;
      $display("FAIL zero_halt_sticky got halt=%0b v=%0b rd=%0b want halt=1 v=0 rd=0",
               bus0.halt, bus0.inst_valid, bus0.imem_rd_en);
    end
`else
    n_cmp++;
    if ({bus0.inst_valid, bus0.inst_pc, bus0.inst, bus0.halt} !== {1'b1, 5'd6, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL zero_as_nop got v=%0b pc=%0d inst=%h halt=%0b want v=1 pc=6 inst=0 halt=0",
               bus0.inst_valid, bus0.inst_pc, bus0.inst, bus0.halt);
    end
`endif
    mem0[6] = w0f(6);
  endtask

  task automatic test_mid_reset();
    reset_dut();
    tick();
    tick();
    tick();
    bus0.inst_ready = 1'b0;
    tick();
    n_cmp++;
    if ({bus0.inst_valid, bus0.inst_pc} !== {1'b1, 5'd1}) begin
      n_err++;
      $display("FAIL midrst_pre got v=%0b pc=%0d want v=1 pc=1", bus0.inst_valid, bus0.inst_pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus0.imem_addr, bus0.imem_rd_en, bus0.inst, bus0.inst_pc, bus0.inst_valid, bus0.halt} !== 45'd0) begin
      n_err++;
      $display("FAIL midrst_outputs got addr=%0d rd=%0b inst=%h pc=%0d v=%0b halt=%0b want all 0",
               bus0.imem_addr, bus0.imem_rd_en, bus0.inst, bus0.inst_pc, bus0.inst_valid, bus0.halt);
    end
    bus0.inst_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({bus0.inst_valid, bus0.inst_pc, bus0.inst} !== {1'b1, 5'(k), w0f(k)}) begin
        n_err++;
        $display("FAIL midrst_restart_w%0d got v=%0b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                 k, bus0.inst_valid, bus0.inst_pc, bus0.inst, k, w0f(k));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      mem0[k] = w0f(k);
      mem1[k] = w1f(k);
    end
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_zero_word();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
